// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states, parity constants
// and the parity helper that the receiver's checker also uses.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_tx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int unsigned PAR_MAX_W = 32;

  // Callers zero-extend narrower words; padding does not change the XOR.
  function automatic logic parity_calc(
    input logic [PAR_MAX_W-1:0] data,
    input logic                 ptype
  );
    return (^data) ^ (ptype == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Per-bit cycle counter for the UART transmitter.
// Strobes the last and second-to-last cycle of every bit period.
module uart_tx_bit_timer #(
  parameter int PRSC_WIDTH = 6
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_en,
  input  logic [PRSC_WIDTH-1:0] i_prescale,
  output logic                  o_bit_end,
  output logic                  o_bit_pre_end
);

  logic [PRSC_WIDTH-1:0] cnt_q;
  logic [PRSC_WIDTH-1:0] cnt_d;
  logic [PRSC_WIDTH-1:0] last;
  logic [PRSC_WIDTH-1:0] pre_last;

  assign last     = i_prescale - PRSC_WIDTH'(1);
  assign pre_last = i_prescale - PRSC_WIDTH'(2);

  assign o_bit_end     = i_en && (cnt_q == last);
  assign o_bit_pre_end = i_en && (cnt_q == pre_last);

  always_comb begin
    cnt_d = cnt_q + PRSC_WIDTH'(1);
    if (!i_en || o_bit_end) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_top.sv
// UART transmitter: start bit, WIDTH data bits LSB-first,
// optional parity bit and one stop bit, each held i_prescale cycles.
module uart_tx_top
  import uart_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int MAX_PRESCALE = 32,
  parameter int PRSC_WIDTH   = $clog2(MAX_PRESCALE) + 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [PRSC_WIDTH-1:0] i_prescale,
  input  logic                  i_parity_enable,
  input  logic                  i_parity_type,
  input  logic                  i_data_valid,
  input  logic [WIDTH-1:0]      i_parallel_data,
  output logic                  o_serial_data,
  output logic                  o_busy,
  output logic                  o_tx_done
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  uart_tx_state_e        state_q, state_d;
  logic [WIDTH-1:0]      shift_q, shift_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [PRSC_WIDTH-1:0] prsc_q, prsc_d;
  logic                  pen_q, pen_d;
  logic                  par_q, par_d;
  logic                  line_q, line_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic bit_end;
  logic bit_pre_end;

  uart_tx_bit_timer #(
    .PRSC_WIDTH(PRSC_WIDTH)
  ) u_timer (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_en         (state_q != IDLE),
    .i_prescale   (prsc_q),
    .o_bit_end    (bit_end),
    .o_bit_pre_end(bit_pre_end)
  );

  // line_d always carries the level of the bit that starts next edge
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    prsc_d    = prsc_q;
    pen_d     = pen_q;
    par_d     = par_q;
    line_d    = line_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        line_d = 1'b1;
        busy_d = 1'b0;
        if (i_data_valid) begin
          shift_d   = i_parallel_data;
          prsc_d    = i_prescale;
          pen_d     = i_parity_enable;
          par_d     = parity_calc(PAR_MAX_W'(i_parallel_data),
                                  i_parity_type);
          bit_cnt_d = '0;
          line_d    = 1'b0;
          busy_d    = 1'b1;
          state_d   = START;
        end
      end
      START: begin
        if (bit_end) begin
          line_d  = shift_q[0];
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            if (pen_q) begin
              line_d  = par_q;
              state_d = PARITY;
            end else begin
              line_d  = 1'b1;
              state_d = STOP;
            end
          end else begin
            shift_d   = shift_q >> 1;
            line_d    = shift_d[0];
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          line_d  = 1'b1;
          state_d = STOP;
        end
      end
      STOP: begin
        if (bit_pre_end) begin
          done_d = 1'b1;
        end
        if (bit_end) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        line_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      prsc_q    <= '0;
      pen_q     <= 1'b0;
      par_q     <= 1'b0;
      line_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      prsc_q    <= prsc_d;
      pen_q     <= pen_d;
      par_q     <= par_d;
      line_q    <= line_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign o_serial_data = line_q;
  assign o_busy        = busy_q;
  assign o_tx_done     = done_q;

endmodule

// File: tb/tb_uart_tx_top.sv
// Bench for uart_tx_top: directed frames plus random frames checked
// cycle by cycle against an ideal line waveform and a mid-bit sampler.
module tb_uart_tx_top;

  localparam int W  = 8;
  localparam int PW = 6;

  logic          i_clk;
  logic          i_rst_n;
  logic [PW-1:0] i_prescale;
  logic          i_parity_enable;
  logic          i_parity_type;
  logic          i_data_valid;
  logic [W-1:0]  i_parallel_data;
  logic          o_serial_data;
  logic          o_busy;
  logic          o_tx_done;

  int total = 0;
  int bad   = 0;

  uart_tx_top #(
    .WIDTH(W),
    .MAX_PRESCALE(32)
  ) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_prescale     (i_prescale),
    .i_parity_enable(i_parity_enable),
    .i_parity_type  (i_parity_type),
    .i_data_valid   (i_data_valid),
    .i_parallel_data(i_parallel_data),
    .o_serial_data  (o_serial_data),
    .o_busy         (o_busy),
    .o_tx_done      (o_tx_done)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #20ms;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Ideal line level for bit slot k of a frame
  function automatic logic exp_bit(input logic [7:0] d, input logic pen,
                                   input logic ptype, input int k);
    logic odd_ones;
    odd_ones = ($countones(d) % 2) == 1;
    if (k == 0) return 1'b0;
    if (k <= W) return d[k-1];
    if (pen && k == W + 1) return odd_ones ^ ptype;
    return 1'b1;
  endfunction

  // Call on a negedge; returns on the negedge of the first idle cycle.
  task automatic send(input logic [7:0] d, input int p, input logic pen,
                      input logic ptype, input bit noise, input bit chain,
                      input logic [7:0] nd);
    int len;
    int k;
    logic [7:0] rx;
    rx  = '0;
    len = (1 + W + int'(pen) + 1) * p;
    i_parallel_data = d;
    i_prescale      = PW'(p);
    i_parity_enable = pen;
    i_parity_type   = ptype;
    i_data_valid    = 1'b1;
    @(posedge i_clk);
    for (int c = 0; c < len; c++) begin
      @(negedge i_clk);
      k = c / p;
      if (c == 0) i_data_valid = 1'b0;
      if (c == 2) begin
        i_parallel_data = 8'($urandom);
        i_prescale      = PW'($urandom_range(4, 32));
        i_parity_enable = 1'($urandom);
        i_parity_type   = 1'($urandom);
      end
      chk("line", 32'(o_serial_data), 32'(exp_bit(d, pen, ptype, k)));
      chk("busy", 32'(o_busy), 32'd1);
      chk("done", 32'(o_tx_done), 32'(c == len - 1));
      if (k >= 1 && k <= W && (c % p) == p / 2) rx[k-1] = o_serial_data;
      if (noise && c == len / 2) begin
        i_data_valid    = 1'b1;
        i_parallel_data = 8'h3C;
      end
      if (noise && c == len - 3) i_data_valid = 1'b0;
      if (chain && c == len - 1) begin
        i_data_valid    = 1'b1;
        i_parallel_data = nd;
      end
    end
    chk("rxbyte", 32'(rx), 32'(d));
    @(negedge i_clk);
    chk("idle_line", 32'(o_serial_data), 32'd1);
    chk("idle_busy", 32'(o_busy), 32'd0);
    chk("idle_done", 32'(o_tx_done), 32'd0);
  endtask

  initial begin
    logic [7:0] cur;
    logic [7:0] nxt;
    bit         ch;
    bit         prev_ch;
    int         p;
    logic       pen;
    logic       pt;

    i_rst_n         = 1'b0;
    i_prescale      = PW'(8);
    i_parity_enable = 1'b0;
    i_parity_type   = 1'b0;
    i_data_valid    = 1'b0;
    i_parallel_data = '0;
    repeat (3) @(negedge i_clk);
    chk("rst_line", 32'(o_serial_data), 32'd1);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_done", 32'(o_tx_done), 32'd0);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    send(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    send(8'hA5, 16, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    send(8'hA5, 16, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    send(8'hA5, 8, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    send(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    send(8'h00, 8, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF);
    send(8'hFF, 8, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    send(8'h81, 4, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    send(8'h7E, 32, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);

    // Abandon a frame during DATA
    i_parallel_data = 8'hA5;
    i_prescale      = PW'(8);
    i_parity_enable = 1'b0;
    i_data_valid    = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_data_valid = 1'b0;
    repeat (19) @(negedge i_clk);
    chk("pre_rst_busy", 32'(o_busy), 32'd1);
    i_rst_n = 1'b0;
    #1;
    chk("mid_rst_line", 32'(o_serial_data), 32'd1);
    chk("mid_rst_busy", 32'(o_busy), 32'd0);
    chk("mid_rst_done", 32'(o_tx_done), 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge i_clk);
      chk("post_rst_line", 32'(o_serial_data), 32'd1);
      chk("post_rst_done", 32'(o_tx_done), 32'd0);
    end
    send(8'h5A, 8, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);

    nxt     = 8'($urandom);
    prev_ch = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cur = nxt;
      nxt = 8'($urandom);
      ch  = (i < 39) && ($urandom_range(0, 1) == 1);
      p   = $urandom_range(4, 20);
      pen = 1'($urandom);
      pt  = 1'($urandom);
      send(cur, p, pen, pt, !ch && !prev_ch && ($urandom_range(0, 3) == 0),
           ch, nxt);
      prev_ch = ch;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_top.md
# uart_tx_top

UART transmitter, the transmit-side counterpart of the UART receiver. It accepts one parallel byte through a valid/busy handshake and serializes it as a frame: start bit, WIDTH data bits LSB-first, optional parity bit, one stop bit. Each bit is held for `i_prescale` clock cycles, so a receiver sharing the same clock and prescale value samples the frame correctly. It sits beside the receiver in the UART peripheral and drives the TX pin.

## Interface
Parameters:
- `WIDTH`, 8: data bits per frame.
- `MAX_PRESCALE`, 32: largest supported cycles-per-bit.
- `PRSC_WIDTH`, $clog2(MAX_PRESCALE)+1: width of the prescale input.

Ports (one clock `i_clk`; reset `i_rst_n` is asynchronous, active-low):
- `i_clk`  in  1  system clock, the same oversampling clock the receiver uses.
- `i_rst_n`  in  1  asynchronous active-low reset.
- `i_prescale`  in  PRSC_WIDTH  clock cycles per bit. Legal range is 4..MAX_PRESCALE.
- `i_parity_enable`  in  1  1 inserts a parity bit after the data bits.
- `i_parity_type`  in  1  0 selects even parity, 1 selects odd parity.
- `i_data_valid`  in  1  request to send `i_parallel_data`.
- `i_parallel_data`  in  WIDTH  byte to transmit.
- `o_serial_data`  out  1  TX line. Registered; idles high.
- `o_busy`  out  1  high while a frame is in flight.
- `o_tx_done`  out  1  one-cycle pulse when the stop bit completes.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP. Reset state is IDLE.
- Outputs in reset: `o_serial_data`=1, `o_busy`=0, `o_tx_done`=0. The bit counter, cycle counter and data/config latches all clear to 0.
- **IDLE**
  - The line is high and `o_busy`=0.
  - When `i_data_valid`=1 the block accepts the request. It latches data, prescale, parity enable and parity type, computes parity (XOR of data, inverted when odd), then moves to START.
  - Changes to these inputs after acceptance have no effect on the current frame.
- **START**: drives 0 for prescale cycles, then moves to DATA.
- **DATA**
  - Drives shift-register bit 0 and shifts right once per bit period.
  - After WIDTH bit periods it moves to PARITY if parity is enabled, otherwise to STOP.
- **PARITY**: drives the latched parity bit for one bit period, then moves to STOP.
- **STOP**
  - Drives 1 for one bit period.
  - In the last cycle of the period it asserts `o_tx_done` and returns to IDLE.
- **Cycle counter**
  - Counts 0..prescale-1 within each bit and wraps to 0 at each bit boundary.
  - Width is PRSC_WIDTH; no overflow is possible for legal prescale values.
- **Bit counter**: counts 0..WIDTH-1 in DATA. Width is $clog2(WIDTH).
- **Handshake**
  - `i_data_valid` is ignored whenever `o_busy`=1. Such requests are dropped, not queued.
  - The upstream source must hold valid until it sees `o_busy` rise.
- **Illegal prescale** (<4): behaviour is undefined. No check is implemented.
- **Reset mid-frame**: the line returns high immediately (asynchronously) and the frame is abandoned. No `o_tx_done` pulse is generated.

## Timing
- **Acceptance**
  - Request accepted at edge N: `o_busy`=1 and `o_serial_data`=0 from edge N+1.
  - Latency from accept to start of the start bit is 1 cycle.
- **Frame length**: (1 + WIDTH + parity_enable + 1) × prescale cycles. Example: 80 cycles for 8N1 at prescale 8.
- **End of frame**
  - `o_tx_done` is high in the final STOP cycle.
  - `o_busy` falls on the following edge, together with the return to IDLE.
- **Back-to-back frames**
  - The earliest new accept is the first IDLE cycle.
  - This gives a minimum inter-frame gap of 1 idle-high cycle beyond the stop bit.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package `uart_pkg`:
  - state enum `uart_tx_state_e` (IDLE, START, DATA, PARITY, STOP)
  - parity-type constants `PAR_EVEN`=0 and `PAR_ODD`=1
  - a `parity_calc` function. The receiver's parity checker uses the same function.
- One sub-module: `uart_tx_bit_timer`.
  - It wraps the cycle counter and emits a `bit_end` strobe on the last cycle of each bit period.
  - The FSM, shift register and parity logic stay in `uart_tx_top`.

## Test plan
- **8N1 frame**: prescale=8, parity off, send 8'hA5.
  - Line sequence: 0,1,0,1,0,0,1,0,1,1, each bit held exactly 8 cycles.
  - `o_tx_done` pulses at cycle 80 after the first low cycle; `o_busy` falls 1 cycle later.
- **Parity**: prescale=16, send 8'hA5.
  - Even parity: parity bit 0.
  - Odd parity: parity bit 1.
  - Frame is 176 cycles in both cases.
- **Request while busy**: assert valid with 8'h3C mid-frame of 8'hA5.
  - 8'h3C is never transmitted.
  - A fresh valid after `o_busy` falls sends 8'h3C correctly.
- **Back-to-back**: hold valid continuously, sending 8'h00 then 8'hFF.
  - Exactly one idle-high cycle separates the first stop bit from the second start bit.
- **Reset mid-frame**: assert `i_rst_n`=0 during DATA.
  - `o_serial_data`=1 and `o_busy`=0 immediately; no `o_tx_done`.
  - The next frame is transmitted cleanly.
- **Loopback**: connect to the receiver with matching prescale and parity settings and send 256 random bytes.
  - Every byte is received with data_valid and no parity or stop errors.
